// File: rtl/shift_pkg.sv
// Shared op codes, FSM encoding and default widths for the iterative shifter.
// SHIFT_ROTATE_EN enables the ROR/ROL ops.
package shift_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int AMT_W_DEF  = 5;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_SLL  = 3'b010;
  localparam logic [2:0] OP_SRL  = 3'b011;
  localparam logic [2:0] OP_SRA  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;
  localparam logic [2:0] OP_ROL  = 3'b110;
  localparam logic [2:0] OP_NOP7 = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Ops that walk the counter; everything else completes in one cycle.
  function automatic logic is_step_op(input logic [2:0] op);
    logic r;
    r = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
`ifdef SHIFT_ROTATE_EN
    r = r || (op == OP_ROR) || (op == OP_ROL);
`endif
    return r;
  endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit shift/rotate step.
// Rotate paths exist only with SHIFT_ROTATE_EN.
module shift_step
  import shift_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] d_next
);

  always_comb begin
    d_next = d;
    unique case (1'b1)
      (op == OP_SLL): d_next = {d[DATA_W-2:0], 1'b0};
      (op == OP_SRL): d_next = {1'b0, d[DATA_W-1:1]};
      (op == OP_SRA): d_next = {d[DATA_W-1], d[DATA_W-1:1]};
`ifdef SHIFT_ROTATE_EN
      (op == OP_ROR): d_next = {d[0], d[DATA_W-1:1]};
      (op == OP_ROL): d_next = {d[DATA_W-2:0], d[DATA_W-1]};
`endif
      default:        d_next = d;
    endcase
  end

endmodule

// File: rtl/iterative_shifter.sv
// Iterative shifter: one bit per clock, start/done handshake.
// Define SHIFT_ROTATE_EN to enable ROR/ROL (otherwise they act as NOP).
module iterative_shifter
  import shift_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int AMT_W  = AMT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [AMT_W-1:0]  shamt_in,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              done
);

  state_t            state;
  logic [2:0]        op_q;
  logic [AMT_W-1:0]  cnt;
  logic [DATA_W-1:0] step;

  shift_step #(.DATA_W(DATA_W)) u_step (
    .op     (op_q),
    .d      (data_out),
    .d_next (step)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_IDLE;
      op_q     <= OP_NOP;
      cnt      <= '0;
      data_out <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q <= op;
            busy <= 1'b1;
            if (op == OP_LOAD)
              data_out <= data_in;
            if (is_step_op(op) && shamt_in != '0) begin
              cnt   <= shamt_in;
              state <= ST_SHIFT;
              done  <= 1'b0;
            end else begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          data_out <= step;
          cnt      <= cnt - AMT_W'(1);
          if (cnt == AMT_W'(1)) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_shifter.sv
// Randomized self-checking bench for iterative_shifter.
// Honors SHIFT_ROTATE_EN in its reference model.
module tb_iterative_shifter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [4:0]  shamt_in = '0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] model = '0;

  iterative_shifter dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .shamt_in (shamt_in),
    .data_in  (data_in),
    .data_out (data_out),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, need completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h need %08h", tag, got, exp);
    end
  endtask

  function automatic bit rot_en();
`ifdef SHIFT_ROTATE_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit walks(input logic [2:0] o);
    case (o)
      3'b010, 3'b011, 3'b100: return 1'b1;
      3'b101, 3'b110:         return rot_en();
      default:                return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_val(input logic [2:0] o, input int n,
                                          input logic [31:0] din,
                                          input logic [31:0] cur);
    logic signed [31:0] s;
    s = cur;
    case (o)
      3'b001: return din;
      3'b010: return cur << n;
      3'b011: return cur >> n;
      3'b100: return 32'(s >>> n);
      3'b101: return (!rot_en() || n == 0) ? cur : (cur >> n) | (cur << (32 - n));
      3'b110: return (!rot_en() || n == 0) ? cur : (cur << n) | (cur >> (32 - n));
      default: return cur;
    endcase
  endfunction

  task automatic run(input logic [2:0] o, input int n,
                     input logic [31:0] din, input bit poke);
    int edges;
    int want;
    logic [31:0] exp;
    exp  = ref_val(o, n, din, model);
    want = walks(o) ? n + 1 : 1;
    @(negedge clk);
    start = 1'b1; op = o; shamt_in = 5'(n); data_in = din;
    @(posedge clk); #1;
    start = 1'b0;
    op = 3'($urandom); shamt_in = 5'($urandom); data_in = $urandom;
    edges = 1;
    while (!done && edges < 100) begin
      check("busy_run", 32'(busy), 32'd1);
      start = 1'b0;
      if (poke && edges == 3) begin
        start = 1'b1; op = 3'b001; data_in = ~exp;
      end
      @(posedge clk); #1;
      edges++;
    end
    start = 1'b0;
    check("latency", 32'(edges), 32'(want));
    check("data", data_out, exp);
    check("busy_done", 32'(busy), 32'd1);
    @(posedge clk); #1;
    check("done_pulse", 32'(done), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
    model = exp;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_data", data_out, 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    run(3'b001, 0, 32'h0000_00FF, 0);
    run(3'b001, 0, 32'h0000_1234, 0);
    run(3'b010, 16, 32'h0, 0);
    check("sll16", data_out, 32'h1234_0000);
    run(3'b001, 0, 32'h8000_0000, 0);
    run(3'b100, 4, 32'h0, 0);
    check("sra4", data_out, 32'hF800_0000);
    run(3'b001, 0, 32'h8000_0000, 0);
    run(3'b011, 4, 32'h0, 0);
    check("srl4", data_out, 32'h0800_0000);
    run(3'b001, 0, 32'h0000_0001, 0);
    run(3'b010, 31, 32'h0, 0);
    check("sll31", data_out, 32'h8000_0000);
    run(3'b010, 0, 32'h0, 0);
    run(3'b111, 7, 32'hDEAD_BEEF, 0);
    run(3'b000, 3, 32'hDEAD_BEEF, 0);
    run(3'b001, 0, 32'hA5A5_0F0F, 0);
    run(3'b010, 8, 32'h0, 1);
    run(3'b001, 0, 32'h1234_5678, 0);
    run(3'b101, 8, 32'h0, 0);
    check("ror8", data_out, rot_en() ? 32'h7812_3456 : 32'h1234_5678);
    run(3'b001, 0, 32'h1234_5678, 0);
    run(3'b110, 4, 32'h0, 0);
    check("rol4", data_out, rot_en() ? 32'h2345_6781 : 32'h1234_5678);

    run(3'b001, 0, 32'hCAFE_F00D, 0);
    @(negedge clk);
    start = 1'b1; op = 3'b011; shamt_in = 5'd20;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    check("mid_rst_data", data_out, 32'h0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    begin
      int seen;
      seen = 0;
      repeat (25) begin
        @(posedge clk); #1;
        if (done) seen++;
      end
      check("no_done_after_rst", 32'(seen), 32'd0);
    end
    model = 32'h0;

    for (int i = 0; i < 40; i++) begin
      logic [2:0] o;
      int n;
      o = 3'($urandom);
      n = $urandom_range(0, 31);
      if (i % 4 == 0) o = 3'b001;
      run(o, n, $urandom, (i % 7 == 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
